// File: rtl/iobs_slave_port.sv
// iobs_slave_port: CPU-side slave port handing I/O accesses to the C16M I/O bus master; define IOBS_POSTED_WRITE_EN to post writes
module iobs_slave_port (
  input  logic CLK,
  input  logic nRES,
  input  logic nAS,
  input  logic IOCS,
  input  logic RW,
  input  logic LDS,
  input  logic UDS,
  input  logic IOACT,
  input  logic IODONE,
  input  logic IOBERR,
  output logic IORDREQ,
  output logic IOWRREQ,
  output logic IOLDS,
  output logic IOUDS,
  output logic IOL_LE,
  output logic nDTACKout,
  output logic nBERRout,
  output logic PWERR
);
`ifdef IOBS_POSTED_WRITE_EN
  localparam logic POST_EN = 1'b1;
`else
  localparam logic POST_EN = 1'b0;
`endif
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACT, S_FIN, S_TERM} state_t;
  state_t r_state, w_next;
  logic r_act_m, r_actr, r_berr_m, r_berrr, r_done_m, r_doner_unused;
  logic r_rw, r_lds, r_uds, r_le, r_err, r_abort, r_posted, r_pwerr, r_dtack, r_berr;
  logic w_access, w_busy, w_term_ok;
  assign w_access  = !nAS && IOCS && r_state == S_IDLE && !r_dtack && !r_berr;
  assign w_busy    = r_state inside {S_REQ, S_ACT, S_FIN};
  assign w_term_ok = r_state == S_FIN && !r_posted && !r_abort;
  assign IORDREQ   = r_state == S_REQ && r_rw;
  assign IOWRREQ   = r_state == S_REQ && !r_rw;
  assign IOLDS     = r_lds;
  assign IOUDS     = r_uds;
  assign IOL_LE    = r_le;
  assign nDTACKout = !r_dtack;
  assign nBERRout  = !r_berr;
  assign PWERR     = r_pwerr;
  // two-flop synchronizers for the C16M-domain status lines (IODONE kept for the I/O side, FSM keys off IOACT)
  always_ff @(posedge CLK) begin
    if (!nRES) begin
      {r_act_m, r_actr, r_berr_m, r_berrr, r_done_m, r_doner_unused} <= '0;
    end else begin
      {r_act_m, r_actr} <= {IOACT, r_act_m};
      {r_berr_m, r_berrr} <= {IOBERR, r_berr_m};
      {r_done_m, r_doner_unused} <= {IODONE, r_done_m};
    end
  end
  // transfer sequencing: a CPU abort lets the I/O side finish, FIN then skips TERM
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_access ? S_REQ : S_IDLE;
      S_REQ:   w_next = r_actr ? S_ACT : S_REQ;
      S_ACT:   w_next = r_actr ? S_ACT : S_FIN;
      S_FIN:   w_next = (w_term_ok && !nAS) ? S_TERM : S_IDLE;
      S_TERM:  w_next = nAS ? S_IDLE : S_TERM;
      default: w_next = S_IDLE;
    endcase
  end
  // state, access latches and terminations; any termination drops the cycle after nAS is seen high
  always_ff @(posedge CLK) begin
    if (!nRES) begin
      r_state  <= S_IDLE;
      r_le     <= 1'b0;
      r_rw     <= 1'b0;
      r_lds    <= 1'b0;
      r_uds    <= 1'b0;
      r_posted <= 1'b0;
      r_err    <= 1'b0;
      r_abort  <= 1'b0;
      r_pwerr  <= 1'b0;
      r_dtack  <= 1'b0;
      r_berr   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_le    <= w_access;
      if (w_access) begin
        r_rw     <= RW;
        r_lds    <= LDS;
        r_uds    <= UDS;
        r_posted <= POST_EN && !RW;
        r_err    <= 1'b0;
        r_abort  <= 1'b0;
      end else begin
        r_err   <= r_err || (r_state == S_ACT && r_berrr);
        r_abort <= r_abort || (w_busy && nAS);
      end
      r_pwerr <= r_pwerr || (r_state == S_FIN && r_posted && r_err);
      r_dtack <= !nAS && (r_dtack || (r_le && r_posted) || (w_term_ok && !r_err));
      r_berr  <= !nAS && (r_berr || (w_term_ok && r_err));
    end
  end
endmodule

// File: tb/tb_iobs_slave_port.sv
// tb_iobs_slave_port: randomized I/O transfers checked every cycle against a per-transfer timing model
module tb_iobs_slave_port;
  localparam int N = 4096;
`ifdef IOBS_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif
  logic CLK = 1'b0;
  logic nRES, nAS, IOCS, RW, LDS, UDS, IOACT, IODONE, IOBERR;
  logic IORDREQ, IOWRREQ, IOLDS, IOUDS, IOL_LE, nDTACKout, nBERRout, PWERR;
  int cyc = 0, tests = 0, fails = 0, prev_r = 2, free_e = 3, last_e = 0;
  bit s_nres[N], s_nas[N], s_iocs[N], s_rw[N], s_lds[N], s_uds[N], s_act[N], s_berr[N], s_done[N];
  bit e_rd[N], e_wr[N], e_le[N], e_lds[N], e_uds[N], e_dtn[N], e_ben[N], e_pw[N];
  logic [7:0] got, want;

  iobs_slave_port dut (
    .CLK(CLK), .nRES(nRES), .nAS(nAS), .IOCS(IOCS), .RW(RW), .LDS(LDS), .UDS(UDS),
    .IOACT(IOACT), .IODONE(IODONE), .IOBERR(IOBERR),
    .IORDREQ(IORDREQ), .IOWRREQ(IOWRREQ), .IOLDS(IOLDS), .IOUDS(IOUDS), .IOL_LE(IOL_LE),
    .nDTACKout(nDTACKout), .nBERRout(nBERRout), .PWERR(PWERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [7:0] g, input logic [7:0] w);
    tests++;
    if (g !== w) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, g, w);
    end
  endtask

  // Edges are absolute posedge numbers. A transfer accepted at edge s requests until the
  // synchronized IOACT rise is seen, finishes three edges after IOACT's low level is sampled,
  // and terminates only if nAS stayed low through FIN (posted writes acknowledge at s+1).
  task automatic plan(input bit rw, input bit lds, input bit uds, input bit err, input int d1,
                      input int len, input bit abort, input int gap, input int hold, input bit rst);
    int r2, s, a, b, r;
    bit posted;
    posted = POSTED && !rw;
    r2 = prev_r + 1 + gap;
    for (int e = prev_r + 1; e < r2; e++) begin
      s_nas[e] = 1'($urandom_range(0, 1));
      s_rw[e]  = 1'($urandom_range(0, 1));
      s_lds[e] = 1'($urandom_range(0, 1));
      s_uds[e] = 1'($urandom_range(0, 1));
    end
    s = r2 > free_e ? r2 : free_e;
    a = s + d1;
    b = a + len;
    r = rst ? s + 1 : posted ? s + 2 + hold : abort ? s + 1 + int'($urandom_range(0, b + 2 - s)) : b + 4 + hold;
    for (int e = r2; e < r; e++) begin
      s_nas[e] = 1'b0; s_iocs[e] = 1'b1; s_rw[e] = rw; s_lds[e] = lds; s_uds[e] = uds;
    end
    e_le[s] = 1'b1;
    for (int e = s; e < N; e++) begin e_lds[e] = lds; e_uds[e] = uds; end
    if (rst) begin
      e_rd[s] = rw; e_wr[s] = !rw;
      s_nres[s + 1] = 1'b0;
      for (int e = s + 1; e < N; e++) begin e_lds[e] = 1'b0; e_uds[e] = 1'b0; e_pw[e] = 1'b0; end
      prev_r = s + 1;
      free_e = s + 2;
    end else begin
      for (int e = s; e <= a + 1; e++) begin e_rd[e] = rw; e_wr[e] = !rw; end
      for (int e = a; e < b; e++) begin s_act[e] = 1'b1; s_berr[e] = err; end
      s_done[b] = 1'b1;
      if (posted) for (int e = s + 1; e < r; e++) e_dtn[e] = 1'b0;
      else for (int e = b + 3; e < r; e++) if (err) e_ben[e] = 1'b0; else e_dtn[e] = 1'b0;
      if (posted && err) for (int e = b + 3; e < N; e++) e_pw[e] = 1'b1;
      prev_r = r;
      free_e = posted ? (r + 1 > b + 4 ? r + 1 : b + 4) : (r > b + 3 ? r + 1 : b + 4);
    end
  endtask

  always @(negedge CLK) if (cyc >= 1 && cyc <= last_e) begin
    got  = {IORDREQ, IOWRREQ, IOL_LE, IOLDS, IOUDS, nDTACKout, nBERRout, PWERR};
    want = {e_rd[cyc], e_wr[cyc], e_le[cyc], e_lds[cyc], e_uds[cyc], e_dtn[cyc], e_ben[cyc], e_pw[cyc]};
    chk("outs", got, want);
    chk("req_excl", {7'd0, IORDREQ && IOWRREQ}, 8'd0);
    if (cyc == 1)  chk("lit_rst_dtack", {7'd0, nDTACKout}, 8'd1);
    if (cyc == 4)  chk("lit_le", {7'd0, IOL_LE}, 8'd1);
    if (cyc == 6)  chk("lit_rdreq_on", {7'd0, IORDREQ}, 8'd1);
    if (cyc == 7)  chk("lit_rdreq_off", {7'd0, IORDREQ}, 8'd0);
    if (cyc == 13) chk("lit_dtack_pre", {7'd0, nDTACKout}, 8'd1);
    if (cyc == 14) chk("lit_dtack_on", {7'd0, nDTACKout}, 8'd0);
    if (cyc == 16) chk("lit_dtack_rel", {7'd0, nDTACKout}, 8'd1);
    if (cyc == 25) chk("lit_berr_on", {6'd0, nBERRout, nDTACKout}, 8'd1);
  end

  initial begin
    for (int e = 0; e < N; e++) begin
      s_nres[e] = 1'b1; s_nas[e] = 1'b1; e_dtn[e] = 1'b1; e_ben[e] = 1'b1;
    end
    s_nres[1] = 1'b0;
    s_nres[2] = 1'b0;
    plan(1, 1, 1, 0, 1, 6, 0, 1, 1, 0);
    plan(1, 0, 1, 1, 2, 3, 0, 0, 0, 0);
    plan(0, 1, 0, 1, 1, 4, 0, 2, 3, 0);
    plan(1, 1, 1, 0, 2, 5, 1, 1, 0, 0);
    plan(0, 1, 1, 0, 3, 5, 1, 0, 0, 0);
    plan(1, 1, 0, 0, 1, 3, 0, 0, 0, 0);
    plan(0, 0, 1, 1, 2, 2, 0, 1, 0, 0);
    for (int k = 0; k < 40; k++)
      plan(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0, int'($urandom_range(1, 3)), int'($urandom_range(2, 7)),
           $urandom_range(0, 4) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 8)), 1'b0);
    plan(1, 1, 1, 0, 3, 4, 0, 1, 0, 1);
    plan(1, 1, 0, 0, 1, 3, 0, 1, 1, 0);
    last_e = prev_r + 8;
    for (int e = 1; e <= last_e; e++) begin
      nRES = s_nres[e]; nAS = s_nas[e]; IOCS = s_iocs[e]; RW = s_rw[e]; LDS = s_lds[e]; UDS = s_uds[e];
      IOACT = s_act[e]; IOBERR = s_berr[e]; IODONE = s_done[e];
      @(posedge CLK);
      @(negedge CLK);
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
